instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit that fills the 32-bit instruction register consumed by the decoder. It reads one instruction as four bytes from the byte-wide RAM port, big-endian, and presents it as `ir` with a one-cycle valid strobe. It owns the program counter. It applies the control-unit verdict (sequential, jump or halt) for the instruction it last fetched.

## Interface
- `ADDR_W`, default 16: RAM byte-address and PC width.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `fetch_start`  in  1  one-cycle pulse: fetch the instruction at `pc`.
- `pc_update`  in  1  one-cycle pulse: apply `cu_op` to the last fetched instruction.
- `cu_op`  in  pkg_cu op type  `CU_NOP`, `CU_JMP` or `CU_HALT`.
- `jmp_offset`  in  24  signed word offset for `CU_JMP`.
- `exit_code`  in  8  halt code, latched on `CU_HALT`.
- `ram_req`  out  1  one-cycle read request.
- `ram_addr`  out  ADDR_W  byte address; valid while `ram_req`=1.
- `ram_ack`  in  1  read complete; `ram_rdata` valid this cycle.
- `ram_rdata`  in  8  read byte.
- `ir`  out  32  assembled instruction.
- `ir_valid`  out  1  one-cycle pulse: `ir` updated.
- `ir_pc`  out  ADDR_W  address of the instruction in `ir`.
- `pc`  out  ADDR_W  address of the next instruction.
- `busy`  out  1  fetch in progress.
- `halted`  out  1  sticky halt flag.
- `halt_code`  out  8  latched exit code.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, HALTED. A 2-bit byte counter `k` counts bytes within a fetch.
- IDLE: on `fetch_start`, latch `ir_pc`←`pc`, set `k`=0, go to REQ.
- REQ: assert `ram_req` with `ram_addr`=`ir_pc`+`k` (mod 2^ADDR_W). Go to WAIT.
- WAIT: on `ram_ack`, write `ram_rdata` into `ir[31-8k -: 8]`; byte k=0 lands in `ir[31:24]`.
  - `k`<3: increment `k`, go to REQ.
  - `k`=3: go to DONE.
- DONE: pulse `ir_valid`, set `pc`←`ir_pc`+4 (mod 2^ADDR_W), go to IDLE.
- `pc_update` in IDLE:
  - `CU_NOP`: `pc` unchanged.
  - `CU_JMP`: `pc`←`ir_pc`+(sign-extend(`jmp_offset`)<<2). Computed at ADDR_W+26 bits, truncated to ADDR_W (wraps).
  - `CU_HALT`: `halt_code`←`exit_code`, `halted`←1, go to HALTED.
- HALTED: absorbing until `rst`; `fetch_start` and `pc_update` ignored; `ram_req`=0.
- Ignored inputs:
  - `fetch_start` or `pc_update` outside IDLE.
  - `ram_ack` outside WAIT.
- `pc_update` and `fetch_start` in the same IDLE cycle: `pc_update` is applied and `fetch_start` is dropped. Control must sequence them on separate cycles.
- `busy`=1 in REQ, WAIT and DONE.
- `rst` at any time, including mid-fetch: state IDLE, `pc`=RESET_PC, `ir`=0, `ir_pc`=RESET_PC, `k`=0, `halt_code`=0, and all strobes, `busy` and `halted` = 0. An outstanding RAM ack after reset is ignored.

## Timing
- All outputs are registered; reset values are as listed above. `ram_addr` is 0 when `ram_req`=0.
- `ram_ack` comes at the earliest one cycle after `ram_req`; unlimited wait states are allowed.
- With single-cycle RAM:
  - `fetch_start` at cycle t0 → `ram_req` at t1, t3, t5, t7 → acks at t2, t4, t6, t8 → `ir_valid` at t9.
  - Earliest next `fetch_start` is t9, when the FSM is already in IDLE.
- Each wait cycle on an ack adds one cycle to the fetch.
- `pc_update` takes effect on `pc` the next cycle; `halted` rises the next cycle.

## Structure
- `pkg_fetch`: FSM state enum and instruction byte count (4).
- `cu_op` uses `pkg_cu` values (`CU_NOP`, `CU_JMP`, `CU_HALT`) unchanged.
- Single module, no sub-module. The byte-lane write into `ir` is indexed by `k`.

## Test plan
- Reset, then RAM[0..3]=11 12 30 04, single-cycle acks, `fetch_start` → `ir`=0x11123004 and `ir_pc`=0 with `ir_valid` at t9; then `pc`=4.
- Acks delayed 3 cycles per byte → the same `ir`, with `ir_valid` at t17.
- After a fetch at `ir_pc`=0x0010, `pc_update` with `CU_JMP`:
  - `jmp_offset`=0xFFFFFE → `pc`=0x0008.
  - `jmp_offset`=0x000003 → `pc`=0x001C.
- Fetch at `ir_pc`=0xFFFE (ADDR_W=16) → bytes read from 0xFFFE, 0xFFFF, 0x0000, 0x0001; then `pc`=0x0002.
- `pc_update` with `CU_HALT` and `exit_code`=0x2A → `halted`=1 and `halt_code`=0x2A. A later `fetch_start` produces no `ram_req`.
- `rst` asserted in WAIT with byte 2 pending → immediate IDLE and `pc`=RESET_PC. A late `ram_ack` is ignored, and the next fetch starts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch slice.
// pkg_cu carries the control-unit verdict encoding used on cu_op.
// pkg_fetch carries the fetch FSM states and the instruction width in bytes.

package pkg_cu;

  typedef enum logic [1:0] {
    CU_NOP  = 2'd0,
    CU_JMP  = 2'd1,
    CU_HALT = 2'd2
  } cu_op_e;

endpackage

package pkg_fetch;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads a 32-bit big-endian instruction one byte
// at a time from a byte-wide RAM port, owns the program counter and applies
// the control-unit verdict (sequential, jump, halt) for the last fetch.

module instr_fetch
  import pkg_cu::*;
  import pkg_fetch::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              pc_update,
  input  cu_op_e            cu_op,
  input  logic [23:0]       jmp_offset,
  input  logic [7:0]        exit_code,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_ack,
  input  logic [7:0]        ram_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [7:0]        halt_code
);

  fetch_state_e      r_state;
  logic [1:0]        r_k;
  logic [31:0]       r_ir;
  logic              r_ir_valid;
  logic [ADDR_W-1:0] r_ir_pc;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ram_req;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_busy;
  logic              r_halted;
  logic [7:0]        r_halt_code;

  logic [1:0]        w_next_k;
  logic              w_last_byte;
  logic [4:0]        w_lane_lsb;
  logic [ADDR_W+25:0] w_jmp_delta;

  // Byte k lands in ir[31-8k -: 8]; for a 2-bit k, (3-k) is simply ~k.
  assign w_next_k    = r_k + 2'd1;
  assign w_last_byte = (r_k == 2'(INSTR_BYTES - 1));
  assign w_lane_lsb  = {~r_k, 3'b000};

  // Word offset sign-extended and scaled to bytes, wide enough that the
  // final truncation to ADDR_W is the only place wrapping happens.
  assign w_jmp_delta = {{ADDR_W{jmp_offset[23]}}, jmp_offset, 2'b00};

  // Fetch FSM with all outputs registered. Completion work (ir_valid pulse,
  // pc advance) is done on the final-ack edge so the cycle that shows
  // ir_valid is already an IDLE cycle and can accept the next fetch_start.
  // ST_DONE is therefore never entered in normal operation and only serves
  // as a safe path back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k         <= 2'd0;
      r_ir        <= 32'd0;
      r_ir_valid  <= 1'b0;
      r_ir_pc     <= RESET_PC;
      r_pc        <= RESET_PC;
      r_ram_req   <= 1'b0;
      r_ram_addr  <= '0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_halt_code <= 8'd0;
    end else begin
      r_ir_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (pc_update) begin
            case (cu_op)
              CU_JMP: begin
                r_pc <= ADDR_W'({26'd0, r_ir_pc} + w_jmp_delta);
              end
              CU_HALT: begin
                r_halt_code <= exit_code;
                r_halted    <= 1'b1;
                r_state     <= ST_HALTED;
              end
              default: begin
              end
            endcase
          end else if (fetch_start) begin
            r_ir_pc    <= r_pc;
            r_k        <= 2'd0;
            r_ram_req  <= 1'b1;
            r_ram_addr <= r_pc;
            r_busy     <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_ram_req  <= 1'b0;
          r_ram_addr <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ram_ack) begin
            r_ir[w_lane_lsb +: 8] <= ram_rdata;
            if (w_last_byte) begin
              r_ir_valid <= 1'b1;
              r_pc       <= r_ir_pc + ADDR_W'(INSTR_BYTES);
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_k        <= w_next_k;
              r_ram_req  <= 1'b1;
              r_ram_addr <= r_ir_pc + ADDR_W'(w_next_k);
              r_state    <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_req   = r_ram_req;
  assign ram_addr  = r_ram_addr;
  assign ir        = r_ir;
  assign ir_valid  = r_ir_valid;
  assign ir_pc     = r_ir_pc;
  assign pc        = r_pc;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign halt_code = r_halt_code;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a RAM responder with programmable ack
// latency serves the main instance, a second instance reset to 0xFFFE covers
// address wrap, and a plain-arithmetic model predicts ir, pc and latency.

module tb_instr_fetch;
  import pkg_cu::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Main instance signals
  logic        fetchStart = 1'b0;
  logic        pcUpdate   = 1'b0;
  cu_op_e      cuOp       = CU_NOP;
  logic [23:0] jmpOffset  = 24'd0;
  logic [7:0]  exitCode   = 8'd0;
  logic        ramReq;
  logic [15:0] ramAddr;
  logic        ramAck     = 1'b0;
  logic [7:0]  ramRdata   = 8'd0;
  logic [31:0] ir;
  logic        irValid;
  logic [15:0] irPc;
  logic [15:0] pc;
  logic        busy;
  logic        halted;
  logic [7:0]  haltCode;

  // Wrap instance signals
  logic        fetchStartB = 1'b0;
  logic        pcUpdateB   = 1'b0;
  cu_op_e      cuOpB       = CU_NOP;
  logic [23:0] jmpOffsetB  = 24'd0;
  logic [7:0]  exitCodeB   = 8'd0;
  logic        ramReqB;
  logic [15:0] ramAddrB;
  logic        ramAckB     = 1'b0;
  logic [7:0]  ramRdataB   = 8'd0;
  logic [31:0] irB;
  logic        irValidB;
  logic [15:0] irPcB;
  logic [15:0] pcB;
  logic        busyB;
  logic        haltedB;
  logic [7:0]  haltCodeB;

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  mem [0:65535];
  int          ackLatency = 1;
  logic [15:0] reqAddrs [$];
  int          modelPc;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetchStart), .pc_update(pcUpdate),
    .cu_op(cuOp), .jmp_offset(jmpOffset), .exit_code(exitCode),
    .ram_req(ramReq), .ram_addr(ramAddr), .ram_ack(ramAck), .ram_rdata(ramRdata),
    .ir(ir), .ir_valid(irValid), .ir_pc(irPc), .pc(pc), .busy(busy),
    .halted(halted), .halt_code(haltCode)
  );

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFE)) dutWrap (
    .clk(clk), .rst(rst), .fetch_start(fetchStartB), .pc_update(pcUpdateB),
    .cu_op(cuOpB), .jmp_offset(jmpOffsetB), .exit_code(exitCodeB),
    .ram_req(ramReqB), .ram_addr(ramAddrB), .ram_ack(ramAckB), .ram_rdata(ramRdataB),
    .ir(irB), .ir_valid(irValidB), .ir_pc(irPcB), .pc(pcB), .busy(busyB),
    .halted(haltedB), .halt_code(haltCodeB)
  );

  // RAM responder: each request is acked ackLatency cycles later with the byte
  // at the requested address; every observed request address is logged.
  initial begin
    logic [15:0] a;
    @(posedge clk); #1;
    forever begin
      if (ramReq === 1'b1) begin
        a = ramAddr;
        reqAddrs.push_back(a);
        repeat (ackLatency) @(posedge clk);
        #1;
        ramAck   = 1'b1;
        ramRdata = mem[a];
        @(posedge clk); #1;
        ramAck   = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] expWord(input int addr);
    return {mem[addr & 16'hFFFF], mem[(addr + 1) & 16'hFFFF],
            mem[(addr + 2) & 16'hFFFF], mem[(addr + 3) & 16'hFFFF]};
  endfunction

  task automatic resetDut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    modelPc = 0;
  endtask

  // Pulses fetch_start and counts cycles until ir_valid (bounded).
  task automatic runFetch(output int cycles);
    fetchStart = 1'b1;
    @(posedge clk); #1;
    fetchStart = 1'b0;
    cycles = 1;
    while (irValid !== 1'b1 && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic applyPcUpdate(input cu_op_e op, input logic [23:0] off, input logic [7:0] code);
    cuOp      = op;
    jmpOffset = off;
    exitCode  = code;
    pcUpdate  = 1'b1;
    @(posedge clk); #1;
    pcUpdate  = 1'b0;
    cuOp      = CU_NOP;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++; if (pc !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_pc: got %h expected 0000", pc); end
    compared++; if (ir !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_ir: got %h expected 00000000", ir); end
    compared++; if (irPc !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_ir_pc: got %h expected 0000", irPc); end
    compared++; if ({busy, halted, irValid, ramReq} !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, halted, irValid, ramReq}); end
    compared++; if (haltCode !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_halt_code: got %h expected 00", haltCode); end
    compared++; if (ramAddr !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_ram_addr: got %h expected 0000", ramAddr); end
    compared++; if (pcB !== 16'hFFFE) begin mismatched++; $display("[TB] FAIL reset_pc_custom: got %h expected fffe", pcB); end
    rst = 1'b0;
    @(posedge clk); #1;
    modelPc = 0;
    compared++; if (pc !== 16'h0000 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_idle: got pc=%h busy=%b expected pc=0000 busy=0", pc, busy); end
  endtask

  task automatic test_basic_fetch();
    int cyc;
    ackLatency = 1;
    reqAddrs.delete();
    runFetch(cyc);
    compared++; if (cyc != 9) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d expected 9", cyc); end
    compared++; if (ir !== 32'h11123004) begin mismatched++; $display("[TB] FAIL basic_ir: got %h expected 11123004", ir); end
    compared++; if (irPc !== 16'h0000) begin mismatched++; $display("[TB] FAIL basic_ir_pc: got %h expected 0000", irPc); end
    compared++;
    if (reqAddrs.size() != 4 || reqAddrs[0] !== 16'd0 || reqAddrs[1] !== 16'd1 || reqAddrs[2] !== 16'd2 || reqAddrs[3] !== 16'd3) begin
      mismatched++; $display("[TB] FAIL basic_req_addrs: got %p expected 0,1,2,3", reqAddrs);
    end
    @(posedge clk); #1;
    compared++; if (irValid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_valid_pulse: got %b expected 0", irValid); end
    compared++; if (pc !== 16'h0004 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_pc_next: got pc=%h busy=%b expected pc=0004 busy=0", pc, busy); end
  endtask

  task automatic test_wait_states();
    int cyc;
    resetDut();
    ackLatency = 3;
    runFetch(cyc);
    compared++; if (cyc != 17) begin mismatched++; $display("[TB] FAIL wait_latency: got %0d expected 17", cyc); end
    compared++; if (ir !== 32'h11123004) begin mismatched++; $display("[TB] FAIL wait_ir: got %h expected 11123004", ir); end
    @(posedge clk); #1;
    compared++; if (pc !== 16'h0004) begin mismatched++; $display("[TB] FAIL wait_pc: got %h expected 0004", pc); end
    ackLatency = 1;
  endtask

  task automatic test_jump();
    int cyc;
    applyPcUpdate(CU_JMP, 24'd4, 8'd0);
    compared++; if (pc !== 16'h0010) begin mismatched++; $display("[TB] FAIL jump_to_10: got %h expected 0010", pc); end
    runFetch(cyc);
    compared++; if (irPc !== 16'h0010 || ir !== expWord(16'h0010)) begin mismatched++; $display("[TB] FAIL jump_fetch: got ir_pc=%h ir=%h expected ir_pc=0010 ir=%h", irPc, ir, expWord(16'h0010)); end
    @(posedge clk); #1;
    applyPcUpdate(CU_JMP, 24'hFFFFFE, 8'd0);
    compared++; if (pc !== 16'h0008) begin mismatched++; $display("[TB] FAIL jump_back: got %h expected 0008", pc); end
    applyPcUpdate(CU_JMP, 24'h000003, 8'd0);
    compared++; if (pc !== 16'h001C) begin mismatched++; $display("[TB] FAIL jump_fwd: got %h expected 001c", pc); end
    applyPcUpdate(CU_NOP, 24'h000007, 8'd0);
    compared++; if (pc !== 16'h001C) begin mismatched++; $display("[TB] FAIL nop_hold: got %h expected 001c", pc); end
  endtask

  task automatic test_collision();
    int n0;
    n0 = reqAddrs.size();
    cuOp       = CU_JMP;
    jmpOffset  = 24'd1;
    pcUpdate   = 1'b1;
    fetchStart = 1'b1;
    @(posedge clk); #1;
    pcUpdate   = 1'b0;
    fetchStart = 1'b0;
    cuOp       = CU_NOP;
    compared++; if (pc !== 16'h0014) begin mismatched++; $display("[TB] FAIL collide_pc: got %h expected 0014", pc); end
    repeat (6) @(posedge clk);
    #1;
    compared++; if (reqAddrs.size() != n0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL collide_no_fetch: got reqs=%0d busy=%b expected reqs=%0d busy=0", reqAddrs.size(), busy, n0); end
  endtask

  task automatic test_wrap();
    logic [7:0]  d [4];
    logic [15:0] expA;
    int          n;
    bit          seen;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    fetchStartB = 1'b1;
    @(posedge clk); #1;
    fetchStartB = 1'b0;
    for (int b = 0; b < 4; b++) begin
      expA = 16'hFFFE + 16'(b);
      n = 0;
      while (ramReqB !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
      seen = (ramReqB === 1'b1);
      compared++; if (!seen || ramAddrB !== expA) begin mismatched++; $display("[TB] FAIL wrap_addr%0d: got req=%b addr=%h expected req=1 addr=%h", b, seen, ramAddrB, expA); end
      @(posedge clk); #1;
      ramAckB   = 1'b1;
      ramRdataB = d[b];
      @(posedge clk); #1;
      ramAckB   = 1'b0;
    end
    n = 0;
    while (irValidB !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    compared++; if (irValidB !== 1'b1 || irB !== {d[0], d[1], d[2], d[3]} || irPcB !== 16'hFFFE) begin
      mismatched++; $display("[TB] FAIL wrap_ir: got valid=%b ir=%h ir_pc=%h expected valid=1 ir=%h ir_pc=fffe", irValidB, irB, irPcB, {d[0], d[1], d[2], d[3]});
    end
    @(posedge clk); #1;
    compared++; if (pcB !== 16'h0002) begin mismatched++; $display("[TB] FAIL wrap_pc: got %h expected 0002", pcB); end
  endtask

  task automatic test_random();
    int          cyc, lat, p, op, offS;
    logic [23:0] off;
    logic [31:0] expIr;
    resetDut();
    for (int it = 0; it < 24; it++) begin
      lat = $urandom_range(1, 4);
      ackLatency = lat;
      p = modelPc;
      expIr = expWord(p);
      runFetch(cyc);
      compared++; if (cyc != 1 + 4 * (lat + 1)) begin mismatched++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", it, cyc, 1 + 4 * (lat + 1)); end
      compared++; if (ir !== expIr || irPc !== 16'(p)) begin mismatched++; $display("[TB] FAIL rand_ir[%0d]: got ir=%h ir_pc=%h expected ir=%h ir_pc=%h", it, ir, irPc, expIr, 16'(p)); end
      modelPc = (p + 4) & 16'hFFFF;
      @(posedge clk); #1;
      compared++; if (pc !== 16'(modelPc)) begin mismatched++; $display("[TB] FAIL rand_seq_pc[%0d]: got %h expected %h", it, pc, 16'(modelPc)); end
      op = $urandom_range(0, 2);
      if (op == 1) begin
        off = 24'($urandom);
        offS = $signed(off);
        modelPc = (p + offS * 4) & 16'hFFFF;
        applyPcUpdate(CU_JMP, off, 8'd0);
        compared++; if (pc !== 16'(modelPc)) begin mismatched++; $display("[TB] FAIL rand_jmp_pc[%0d]: got %h expected %h off=%h", it, pc, 16'(modelPc), off); end
      end else if (op == 2) begin
        applyPcUpdate(CU_NOP, 24'($urandom), 8'($urandom));
        compared++; if (pc !== 16'(modelPc)) begin mismatched++; $display("[TB] FAIL rand_nop_pc[%0d]: got %h expected %h", it, pc, 16'(modelPc)); end
      end
    end
    ackLatency = 1;
  endtask

  task automatic test_halt();
    int n0;
    applyPcUpdate(CU_HALT, 24'd0, 8'h2A);
    compared++; if (halted !== 1'b1 || haltCode !== 8'h2A) begin mismatched++; $display("[TB] FAIL halt_flag: got halted=%b code=%h expected halted=1 code=2a", halted, haltCode); end
    n0 = reqAddrs.size();
    fetchStart = 1'b1;
    @(posedge clk); #1;
    fetchStart = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    compared++; if (reqAddrs.size() != n0 || ramReq !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_no_fetch: got reqs=%0d busy=%b expected reqs=%0d busy=0", reqAddrs.size(), busy, n0); end
    applyPcUpdate(CU_JMP, 24'h000010, 8'h55);
    compared++; if (pc !== 16'(modelPc) || haltCode !== 8'h2A || halted !== 1'b1) begin mismatched++; $display("[TB] FAIL halt_sticky: got pc=%h code=%h halted=%b expected pc=%h code=2a halted=1", pc, haltCode, halted, 16'(modelPc)); end
  endtask

  task automatic test_reset_mid_fetch();
    int cyc, n;
    bit sawValid, sawBusy;
    resetDut();
    ackLatency = 4;
    reqAddrs.delete();
    fetchStart = 1'b1;
    @(posedge clk); #1;
    fetchStart = 1'b0;
    n = 0;
    while (reqAddrs.size() < 3 && n < 100) begin @(posedge clk); #2; n++; end
    compared++; if (reqAddrs.size() != 3) begin mismatched++; $display("[TB] FAIL midrst_reach_byte2: got reqs=%0d expected 3", reqAddrs.size()); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    compared++; if (busy !== 1'b0 || pc !== 16'h0000 || irPc !== 16'h0000 || ir !== 32'd0 || ramReq !== 1'b0) begin
      mismatched++; $display("[TB] FAIL midrst_clear: got busy=%b pc=%h ir_pc=%h ir=%h req=%b expected 0/0000/0000/00000000/0", busy, pc, irPc, ir, ramReq);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    modelPc = 0;
    sawValid = 1'b0;
    sawBusy  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      sawValid |= irValid;
      sawBusy  |= busy;
    end
    compared++; if (sawValid || sawBusy || ir !== 32'd0) begin mismatched++; $display("[TB] FAIL midrst_late_ack: got valid=%b busy=%b ir=%h expected 0/0/00000000", sawValid, sawBusy, ir); end
    ackLatency = 1;
    reqAddrs.delete();
    runFetch(cyc);
    compared++; if (reqAddrs.size() == 0 || reqAddrs[0] !== 16'h0000 || ir !== 32'h11123004 || cyc != 9) begin
      mismatched++; $display("[TB] FAIL midrst_refetch: got first_addr=%h ir=%h cycles=%0d expected 0000/11123004/9", (reqAddrs.size() > 0) ? reqAddrs[0] : 16'hXXXX, ir, cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11;
    mem[1] = 8'h12;
    mem[2] = 8'h30;
    mem[3] = 8'h04;
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_jump();
    test_collision();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
